// File: rtl/led_pattern_controller.sv
// Go Board switch/LED sequencer: synchronises and debounces four switches, steps a
// four-mode FSM on switch 1 and drives the LEDs as passthrough, toggles, chaser or blinker.
module led_pattern_controller #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int STEP_LIMIT     = 6250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [1:0] o_Mode
);

  localparam int DB_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam int ST_W = (STEP_LIMIT > 1) ? $clog2(STEP_LIMIT) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STEP_LIMIT - 1);

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  logic [3:0]      raw;
  logic [3:0]      sync_1;
  logic [3:0]      sync_2;
  logic [3:0]      stable;
  logic [3:0]      prev;
  logic [DB_W-1:0] db_cnt [4];
  logic [3:0]      press;

  assign raw   = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
  assign press = stable & ~prev;

  // A level is accepted only after it has differed from stable for DEBOUNCE_LIMIT cycles in a row.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_1 <= '0;
      sync_2 <= '0;
      stable <= '0;
      prev   <= '0;
      for (int k = 0; k < 4; k++) db_cnt[k] <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      prev   <= stable;
      for (int k = 0; k < 4; k++) begin
        if (sync_2[k] != stable[k]) begin
          if (db_cnt[k] == DB_LAST) begin
            stable[k] <= sync_2[k];
            db_cnt[k] <= '0;
          end else begin
            db_cnt[k] <= db_cnt[k] + DB_W'(1);
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

  mode_t           mode;
  logic [2:0]      latch;
  logic [3:0]      pattern;
  logic            dir_rev;
  logic            run;
  logic            blink;
  logic [ST_W-1:0] timer;
  logic [3:0]      leds;
  logic            hold;
  logic            tick;

  assign hold = (mode == MODE_CHASE) && !run;
  assign tick = (timer == ST_LAST) && !hold;

  // A mode advance takes priority over every other press in the same cycle.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      mode    <= MODE_PASS;
      latch   <= '0;
      pattern <= 4'b0001;
      dir_rev <= 1'b0;
      run     <= 1'b1;
      blink   <= 1'b0;
      timer   <= '0;
      leds    <= '0;
    end else begin
      if (press[0]) begin
        timer <= '0;
        case (mode)
          MODE_PASS: begin
            mode  <= MODE_TOGGLE;
            latch <= '0;
          end
          MODE_TOGGLE: begin
            mode    <= MODE_CHASE;
            pattern <= 4'b0001;
            dir_rev <= 1'b0;
            run     <= 1'b1;
          end
          MODE_CHASE: begin
            mode  <= MODE_BLINK;
            blink <= 1'b1;
          end
          default: mode <= MODE_PASS;
        endcase
      end else begin
        if (!hold) timer <= tick ? '0 : timer + ST_W'(1);
        case (mode)
          MODE_TOGGLE: latch <= latch ^ press[3:1];
          MODE_CHASE: begin
            if (press[1]) dir_rev <= ~dir_rev;
            if (press[2]) run <= ~run;
            // Direction is sampled at the tick, so a reversal keeps the current position.
            if (tick) pattern <= dir_rev ? {pattern[0], pattern[3:1]}
                                         : {pattern[2:0], pattern[3]};
          end
          MODE_BLINK: if (tick) blink <= ~blink;
          default: ;
        endcase
      end

      case (mode)
        MODE_PASS:   leds <= stable;
        MODE_TOGGLE: leds <= {latch, 1'b0};
        MODE_CHASE:  leds <= pattern;
        default:     leds <= {4{blink}};
      endcase
    end
  end

  assign o_LED_1 = leds[0];
  assign o_LED_2 = leds[1];
  assign o_LED_3 = leds[2];
  assign o_LED_4 = leds[3];
  assign o_Mode  = mode;

endmodule

// File: tb/tb_led_pattern_controller.sv
// Directed bench for led_pattern_controller with short debounce/step limits:
// a press/expectation table plus cycle-exact sequences for chase, pause, blink and reset.
module tb_led_pattern_controller;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic       led_1, led_2, led_3, led_4;
  logic [1:0] mode;
  logic [3:0] leds;

  int n_checks = 0;
  int n_fail   = 0;

  assign leds = {led_4, led_3, led_2, led_1};

  led_pattern_controller #(
    .DEBOUNCE_LIMIT(4),
    .STEP_LIMIT    (8)
  ) dut (
    .i_Clk     (clk),
    .i_Rst_L   (rst_n),
    .i_Switch_1(sw[0]),
    .i_Switch_2(sw[1]),
    .i_Switch_3(sw[2]),
    .i_Switch_4(sw[3]),
    .o_LED_1   (led_1),
    .o_LED_2   (led_2),
    .o_LED_3   (led_3),
    .o_LED_4   (led_4),
    .o_Mode    (mode)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw_mask;
    logic [1:0] exp_mode;
    logic       chk_leds;
    logic [3:0] exp_leds;
  } vec_t;

  vec_t vecs [10];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Press the given switches long enough to debounce, then release and let the release settle.
  task automatic press_sw(input logic [3:0] mask);
    sw = mask;
    repeat (10) cyc();
    sw = 4'b0000;
    repeat (12) cyc();
  endtask

  function automatic logic [3:0] chase_exp(input int c);
    if (c < 16) return 4'b0001;
    if (c < 24) return 4'b0010;
    if (c < 32) return 4'b0100;
    if (c < 40) return 4'b0010;
    if (c < 48) return 4'b0001;
    if (c < 97) return 4'b1000;
    if (c < 105) return 4'b0100;
    return 4'b0010;
  endfunction

  initial begin
    vecs[0] = '{4'b0001, 2'd1, 1'b1, 4'b0000};
    vecs[1] = '{4'b1000, 2'd1, 1'b1, 4'b1000};
    vecs[2] = '{4'b1000, 2'd1, 1'b1, 4'b0000};
    vecs[3] = '{4'b0010, 2'd1, 1'b1, 4'b0010};
    vecs[4] = '{4'b0100, 2'd1, 1'b1, 4'b0110};
    vecs[5] = '{4'b0001, 2'd2, 1'b0, 4'b0000};
    vecs[6] = '{4'b0001, 2'd3, 1'b0, 4'b0000};
    vecs[7] = '{4'b0001, 2'd0, 1'b1, 4'b0000};
    vecs[8] = '{4'b0010, 2'd0, 1'b1, 4'b0000};
    vecs[9] = '{4'b0001, 2'd1, 1'b1, 4'b0000};

    rst_n = 1'b0;
    sw    = 4'b0000;
    repeat (3) cyc();
    check("reset_leds", leds, 4'b0000);
    check("reset_mode", {2'b00, mode}, 4'd0);
    rst_n = 1'b1;
    repeat (2) cyc();

    // Passthrough latency: sw2 held 10 cycles, LED2 follows 7 cycles behind each edge.
    sw = 4'b0010;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (c == 10) sw = 4'b0000;
      check("pass_led2", leds, (c >= 7 && c <= 16) ? 4'b0010 : 4'b0000);
      check("pass_mode", {2'b00, mode}, 4'd0);
    end

    // A 3-cycle glitch on sw3 must never reach the LED.
    sw = 4'b0100;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (c == 3) sw = 4'b0000;
      check("glitch_led3", leds, 4'b0000);
    end

    for (int i = 0; i < 10; i++) begin
      press_sw(vecs[i].sw_mask);
      check($sformatf("vec%0d_mode", i), {2'b00, mode}, {2'b00, vecs[i].exp_mode});
      if (vecs[i].chk_leds) check($sformatf("vec%0d_leds", i), leds, vecs[i].exp_leds);
    end

    // Enter CHASE, reverse at 0100, pause for 40 cycles, resume with the remaining count.
    sw = 4'b0001;
    for (int c = 1; c <= 106; c++) begin
      cyc();
      if (c == 6) check("chase_mode_before", {2'b00, mode}, 4'd1);
      if (c == 7) check("chase_leds_entry", leds, 4'b0000);
      if (c >= 7) check("chase_mode", {2'b00, mode}, 4'd2);
      if (c >= 8) check($sformatf("chase_leds_c%0d", c), leds, chase_exp(c));
      sw[0] = (c < 10);
      sw[1] = (c >= 20 && c < 30);
      sw[2] = (c >= 43 && c < 53) || (c >= 84 && c < 94);
    end
    sw = 4'b0000;

    // sw1 and sw2 together: mode advance wins, BLINK starts with all LEDs on.
    sw = 4'b0011;
    for (int c = 1; c <= 24; c++) begin
      cyc();
      if (c == 10) sw = 4'b0000;
      if (c == 6) check("blink_mode_before", {2'b00, mode}, 4'd2);
      if (c >= 7) check("blink_mode", {2'b00, mode}, 4'd3);
      if (c >= 8 && c <= 15) check("blink_on", leds, 4'b1111);
      if (c >= 16 && c <= 23) check("blink_off", leds, 4'b0000);
      if (c == 24) check("blink_on_again", leds, 4'b1111);
    end

    // Asynchronous reset mid-step, observed before any further clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_leds", leds, 4'b0000);
    check("async_reset_mode", {2'b00, mode}, 4'd0);

    // Switch 1 held through reset yields exactly one press.
    sw = 4'b0001;
    cyc();
    rst_n = 1'b1;
    repeat (20) cyc();
    check("held_reset_mode", {2'b00, mode}, 4'd1);
    sw = 4'b0000;
    repeat (20) cyc();
    check("held_reset_mode_once", {2'b00, mode}, 4'd1);
    check("held_reset_leds", leds, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
